// File: rtl/lcd_timing_pkg.sv
// Shared timing helpers, FSM state encoding and HD44780 opcodes for the LCD path.
package lcd_timing_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_EXEC    = 3'd5
    } lcd_state_t;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    // Clock cycles covering t_ns, rounded up, never less than one.
    function automatic int unsigned cycles_from_ns(input longint unsigned t_ns,
                                                   input longint unsigned clk_hz);
        longint unsigned n;
        n = (t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        if (n == 64'd0) n = 64'd1;
        return 32'(n);
    endfunction

    // Clock cycles covering t_us, rounded up, never less than one.
    function automatic int unsigned cycles_from_us(input longint unsigned t_us,
                                                   input longint unsigned clk_hz);
        longint unsigned n;
        n = (t_us * clk_hz + 64'd999_999) / 64'd1_000_000;
        if (n == 64'd0) n = 64'd1;
        return 32'(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear Display, Return Home (and its 0x03 alias) need the long execution wait.
    function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed state of the LCD bus FSM.
module lcd_delay_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_count;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge clock) begin
        if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done_c = (r_count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 physical-layer write timing: power-up wait, setup, E pulse, hold and exec delay.
module lcd_bus_driver
    import lcd_timing_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned T_SETUP_NS      = 60,
    parameter int unsigned T_EPW_NS        = 460,
    parameter int unsigned T_HOLD_NS       = 20,
    parameter int unsigned T_EXEC_SHORT_US = 40,
    parameter int unsigned T_EXEC_LONG_US  = 1640,
    parameter int unsigned T_POWERUP_US    = 40000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int unsigned N_SETUP = cycles_from_ns(64'(T_SETUP_NS), 64'(CLK_FREQ_HZ));
    localparam int unsigned N_EPW   = cycles_from_ns(64'(T_EPW_NS), 64'(CLK_FREQ_HZ));
    localparam int unsigned N_HOLD  = cycles_from_ns(64'(T_HOLD_NS), 64'(CLK_FREQ_HZ));
    localparam int unsigned N_SHORT = cycles_from_us(64'(T_EXEC_SHORT_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned N_LONG  = cycles_from_us(64'(T_EXEC_LONG_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned N_PWR   = cycles_from_us(64'(T_POWERUP_US), 64'(CLK_FREQ_HZ));

    localparam int unsigned N_MAX = max_u(max_u(max_u(N_SETUP, N_EPW), max_u(N_HOLD, N_SHORT)),
                                          max_u(N_LONG, N_PWR));
    localparam int unsigned CNT_W = $clog2(N_MAX) + 1;

    // A state lasting N cycles loads N-1 and leaves on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(N_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(N_EPW - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(N_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(N_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(N_LONG - 1);
    localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(N_PWR - 1);

    lcd_state_t       r_state;
    logic             r_ready;
    logic             r_busy;
    logic             r_e;
    logic             r_rs;
    logic [7:0]       r_db;

    logic             w_done;
    logic             w_accept;
    logic             w_advance;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;

    lcd_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clock      (clock),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done_c   (w_done)
    );

    // Decide when the current state ends and what delay the next state starts with.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && cmd_valid && r_ready;
        w_advance  = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_POWERUP: begin
                w_advance  = w_done;
                w_load_val = '0;
            end
            ST_IDLE: begin
                w_advance  = w_accept;
                w_load_val = LD_SETUP;
            end
            ST_SETUP: begin
                w_advance  = w_done;
                w_load_val = LD_EPW;
            end
            ST_PULSE: begin
                w_advance  = w_done;
                w_load_val = LD_HOLD;
            end
            ST_HOLD: begin
                w_advance  = w_done;
                w_load_val = is_long_exec(r_rs, r_db) ? LD_LONG : LD_SHORT;
            end
            ST_EXEC: begin
                w_advance  = w_done;
                w_load_val = '0;
            end
            default: begin
                w_advance  = 1'b0;
                w_load_val = '0;
            end
        endcase
        if (reset) begin
            w_load_val = LD_PWR;
        end
        w_load = reset || w_advance;
    end

    // Transfer sequencer with registered handshake and LCD pin outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_POWERUP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_db    <= 8'h00;
        end else if (w_advance) begin
            case (r_state)
                ST_POWERUP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                ST_IDLE: begin
                    r_state <= ST_SETUP;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_rs    <= cmd_rs;
                    r_db    <= cmd_data;
                end
                ST_SETUP: begin
                    r_state <= ST_PULSE;
                    r_e     <= 1'b1;
                end
                ST_PULSE: begin
                    r_state <= ST_HOLD;
                    r_e     <= 1'b0;
                end
                ST_HOLD: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_POWERUP;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_e     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign lcd_e     = r_e;
    assign lcd_rs    = r_rs;
    assign lcd_db    = r_db;
    assign lcd_rw    = 1'b0;

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
Physical-layer timing stage that sits directly downstream of the display control unit. The control unit produces RS and DB values for HD44780-class LCD commands and characters; this block accepts them one at a time over a valid/ready handshake. It drives the LCD pins with correct address setup, E pulse width, hold and command-execution delays. It also enforces the controller power-up wait after reset, so upstream logic never counts time itself.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency
T_SETUP_NS, 60, RS/DB valid before E rises (tAS)
T_EPW_NS, 460, E high pulse width (PWEH)
T_HOLD_NS, 20, RS/DB held after E falls (tAH)
T_EXEC_SHORT_US, 40, execution wait for ordinary commands/data
T_EXEC_LONG_US, 1640, execution wait for Clear Display / Return Home
T_POWERUP_US, 40000, wait after reset before first transfer

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  upstream has a byte to send
cmd_rs  in  1  0 = instruction, 1 = data
cmd_data  in  8  byte to send
cmd_ready  out  1  block can accept a byte this cycle
busy  out  1  transfer or power-up wait in progress (equals ~cmd_ready)
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_db  out  8  LCD data bus

Behaviour:
- Derived cycle counts: N_X = ceil(T_X × CLK_FREQ_HZ / 1e9 or 1e6), with a minimum of 1.
  - Compute in 64-bit integer arithmetic at elaboration.
  - Defaults: N_SETUP=3, N_EPW=23, N_HOLD=1, N_SHORT=2000, N_LONG=82000, N_PWR=2_000_000.
- Counter width: $clog2(max of all N)+1. A single down-counter is shared across states.
- Reset (synchronous):
  - state=POWERUP, counter=N_PWR-1.
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=8'h00, cmd_ready=0, busy=1.
- States:
  - POWERUP: count down; at 0 go to IDLE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_rs/cmd_data into lcd_rs/lcd_db at that edge, then go to SETUP.
  - SETUP: N_SETUP cycles, E=0, then PULSE.
  - PULSE: E=1 for exactly N_EPW cycles, then HOLD.
  - HOLD: E=0 for N_HOLD cycles, then EXEC.
  - EXEC: N_LONG or N_SHORT cycles, then IDLE.
- Long-exec decision: the latched byte is long when rs==0 && data[7:2]==0 && data[1:0]!=0 (0x01, 0x02, 0x03). All other bytes are short, including rs=1 with 0x01.
- Latency: from the acceptance edge, cmd_ready is high again after N_SETUP+N_EPW+N_HOLD+N_EXEC cycles.
- cmd_ready is registered and is 0 in every state except IDLE. It drops on the cycle after acceptance.
- Acceptance: cmd_valid while busy is ignored; inputs are not sampled and no command is queued. Upstream must hold valid/data until ready.
- lcd_rs/lcd_db are stable from acceptance through the end of EXEC. They keep their last value in IDLE and change only on acceptance.
- lcd_e is registered and glitch-free; it is high only in PULSE.
- Reset during any state:
  - The next edge forces E=0 and restarts POWERUP with the full N_PWR wait.
  - The in-flight command is discarded.

Decomposition:
- Shared package lcd_timing_pkg holds:
  - the state enum;
  - the cycles_from_ns / cycles_from_us functions (ceil, minimum 1);
  - opcode constants LCD_CLEAR=8'h01, LCD_HOME=8'h02.
- The display control unit will reuse these opcode constants.
- One natural sub-module, lcd_delay_counter: load value, load strobe, done flag. The FSM loads it on every state entry.

Test Plan:
- Power-up (T_POWERUP_US=10 → N_PWR=500): release reset, hold cmd_valid=1 → cmd_ready=0 and lcd_e=0 for exactly 500 cycles, then cmd_ready=1; no transfer before that.
- Data write, rs=1, 0x41:
  - E rises 3 cycles after the acceptance edge and stays high 23 cycles.
  - RS=1 and DB=0x41 are stable from acceptance until ready returns.
  - cmd_ready returns 3+23+1+2000=2027 cycles after acceptance.
- Exec length: 0x01/rs=0 → exec 82000 cycles. Same for 0x02 and 0x03. 0x38/rs=0, 0x04/rs=0 and 0x01/rs=1 → 2000 cycles.
- Back-to-back: hold cmd_valid high with a new byte changed mid-transfer → changed bytes are not sampled while busy. Next accept occurs on the first cycle cmd_ready=1, with exactly one E pulse per accepted byte.
- Reset mid-PULSE: assert reset while lcd_e=1 → E=0, lcd_db=0x00, cmd_ready=0 after the next edge. Full power-up wait follows and the aborted byte is never re-sent.
- Init sequence 0x38, 0x38, 0x0C, 0x01, 0x06 (rs=0) → five E pulses with DB matching in order. Measured gaps match short/short/short/long/short.
